// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master: FSM state encoding and
// chip-select index width.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } spi_state_t;

  function automatic int cs_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_master_param_clkgen.sv
// SCLK half-period timer: tick is high on the last clk cycle of each
// half-period; clear restarts the count so a new transfer is phase-aligned.
module spi_clkgen #(
  parameter int CLK_DIV = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master (all four modes, one-hot active-low chip selects).
// Define SPI_MASTER_RX_EN to add MISO capture (miso, rx_data, rx_valid).
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W  = 18,
  parameter int CLK_DIV = 32,
  parameter int CPOL    = 0,
  parameter int CPHA    = 0,
  parameter int NUM_CS  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  input  logic [DATA_W-1:0]           tx_data,
  input  logic [cs_width(NUM_CS)-1:0] cs_sel,
  output logic                        sclk,
  output logic                        mosi,
  output logic [NUM_CS-1:0]           cs_n,
  output logic                        busy,
  output logic                        done
`ifdef SPI_MASTER_RX_EN
  ,
  input  logic                        miso,
  output logic [DATA_W-1:0]           rx_data,
  output logic                        rx_valid
`endif
);

  localparam int   CS_W   = cs_width(NUM_CS);
  localparam int   HW     = $clog2(2 * DATA_W + 1);
  localparam logic CPOL_L = (CPOL != 0);
  localparam logic CPHA_L = (CPHA != 0);

  spi_state_t        state_q;
  logic [HW-1:0]     h_q;
  logic [DATA_W-1:0] tx_shift_q;
  logic              sclk_q;
  logic              mosi_q;
  logic [NUM_CS-1:0] cs_n_q;
  logic              done_q;

  logic              tick;
  logic              accept;
  logic              last_h;
  logic [HW-1:0]     h_nx;
  logic              lead_nx;
  logic              edge_evt;
  logic              shift_evt;
  logic [NUM_CS-1:0] cs_dec;

  assign tx_ready = (state_q == IDLE) && !rst;
  assign accept   = tx_valid && tx_ready;
  assign busy     = (state_q != IDLE);
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;
  assign done     = done_q;

  // An out-of-range cs_sel matches no line, so nothing is asserted.
  for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs
    assign cs_dec[gi] = (cs_sel != CS_W'(gi));
  end

  spi_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .tick  (tick)
  );

  // Every SCLK edge starts a new half-period h_nx; even h is a leading edge.
  always_comb begin
    last_h    = (h_q == HW'(2 * DATA_W - 1));
    h_nx      = (state_q == SETUP) ? '0 : h_q + HW'(1);
    lead_nx   = ~h_nx[0];
    edge_evt  = tick && ((state_q == SETUP) || (state_q == SHIFT && !last_h));
    shift_evt = edge_evt &&
                (CPHA_L ? lead_nx : (!lead_nx && (h_nx != HW'(2 * DATA_W - 1))));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      h_q        <= '0;
      tx_shift_q <= '0;
      sclk_q     <= CPOL_L;
      mosi_q     <= 1'b0;
      cs_n_q     <= '1;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= SETUP;
            h_q     <= '0;
            cs_n_q  <= cs_dec;
            if (CPHA_L) begin
              tx_shift_q <= tx_data;
            end else begin
              mosi_q     <= tx_data[DATA_W-1];
              tx_shift_q <= tx_data << 1;
            end
          end
        end
        SETUP: if (tick) state_q <= SHIFT;
        SHIFT: if (tick && last_h) state_q <= HOLD;
        HOLD: begin
          if (tick) begin
            state_q <= IDLE;
            cs_n_q  <= '1;
            mosi_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (edge_evt) begin
        h_q    <= h_nx;
        sclk_q <= CPOL_L ^ lead_nx;
      end
      if (shift_evt) begin
        mosi_q     <= tx_shift_q[DATA_W-1];
        tx_shift_q <= tx_shift_q << 1;
      end
    end
  end

`ifdef SPI_MASTER_RX_EN
  logic [DATA_W-1:0] rx_shift_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic              sample_evt;

  assign sample_evt = edge_evt && (CPHA_L ? !lead_nx : lead_nx);
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (accept)          rx_shift_q <= '0;
      else if (sample_evt) rx_shift_q <= DATA_W'({rx_shift_q, miso});
      if (state_q == HOLD && tick) begin
        rx_data_q  <= rx_shift_q;
        rx_valid_q <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: three instances (mode 0 / mode 3 /
// wide word), table of single transfers plus back-to-back and reset sequences.
module tb_spi_master_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        tx_valid_r [3];
  logic [17:0] tx_data_r  [3];
  logic [2:0]  tx_sel_r   [3];

  logic       sclk_a, mosi_a, busy_a, done_a, ready_a;
  logic       sclk_b, mosi_b, busy_b, done_b, ready_b;
  logic       sclk_c, mosi_c, busy_c, done_c, ready_c;
  logic [3:0] cs_n_a;
  logic [2:0] cs_n_b;
  logic [0:0] cs_n_c;

  logic [2:0] sclk_w, mosi_w, busy_w, done_w, ready_w;
  logic [3:0] cs_n_w [3];
  logic [2:0] cpol_w;

  int n_vec  = 0;
  int n_miss = 0;

  assign cpol_w = 3'b010;

  always_comb begin
    sclk_w    = {sclk_c, sclk_b, sclk_a};
    mosi_w    = {mosi_c, mosi_b, mosi_a};
    busy_w    = {busy_c, busy_b, busy_a};
    done_w    = {done_c, done_b, done_a};
    ready_w   = {ready_c, ready_b, ready_a};
    cs_n_w[0] = cs_n_a;
    cs_n_w[1] = {1'b1, cs_n_b};
    cs_n_w[2] = {3'b111, cs_n_c};
  end

`ifdef SPI_MASTER_RX_EN
  logic [7:0]  rx_a, rx_b;
  logic [17:0] rx_c;
  logic        rxv_a, rxv_b, rxv_c;
  logic        miso_c;
  logic [17:0] rx_w [3];
  logic [2:0]  rxv_w;
  assign miso_c = ~mosi_c;
  always_comb begin
    rx_w[0] = {10'd0, rx_a};
    rx_w[1] = {10'd0, rx_b};
    rx_w[2] = rx_c;
    rxv_w   = {rxv_c, rxv_b, rxv_a};
  end
`endif

  spi_master_param #(.DATA_W(8), .CLK_DIV(4), .CPOL(0), .CPHA(0), .NUM_CS(4)) u_a (
    .clk(clk), .rst(rst), .tx_valid(tx_valid_r[0]), .tx_ready(ready_a),
    .tx_data(tx_data_r[0][7:0]), .cs_sel(tx_sel_r[0][1:0]),
    .sclk(sclk_a), .mosi(mosi_a), .cs_n(cs_n_a), .busy(busy_a), .done(done_a)
`ifdef SPI_MASTER_RX_EN
    , .miso(mosi_a), .rx_data(rx_a), .rx_valid(rxv_a)
`endif
  );

  spi_master_param #(.DATA_W(8), .CLK_DIV(4), .CPOL(1), .CPHA(1), .NUM_CS(3)) u_b (
    .clk(clk), .rst(rst), .tx_valid(tx_valid_r[1]), .tx_ready(ready_b),
    .tx_data(tx_data_r[1][7:0]), .cs_sel(tx_sel_r[1][1:0]),
    .sclk(sclk_b), .mosi(mosi_b), .cs_n(cs_n_b), .busy(busy_b), .done(done_b)
`ifdef SPI_MASTER_RX_EN
    , .miso(mosi_b), .rx_data(rx_b), .rx_valid(rxv_b)
`endif
  );

  spi_master_param #(.DATA_W(18), .CLK_DIV(32), .CPOL(0), .CPHA(0), .NUM_CS(1)) u_c (
    .clk(clk), .rst(rst), .tx_valid(tx_valid_r[2]), .tx_ready(ready_c),
    .tx_data(tx_data_r[2]), .cs_sel(tx_sel_r[2][0:0]),
    .sclk(sclk_c), .mosi(mosi_c), .cs_n(cs_n_c), .busy(busy_c), .done(done_c)
`ifdef SPI_MASTER_RX_EN
    , .miso(miso_c), .rx_data(rx_c), .rx_valid(rxv_c)
`endif
  );

  typedef struct {
    int          dut;
    logic [17:0] data;
    logic [2:0]  sel;
    logic [3:0]  exp_csn;
    logic [17:0] exp_bits;
    int          exp_low;
    int          exp_done;
    int          exp_edges;
    logic [17:0] exp_rx;
    logic        exp_mosi1;
  } vec_t;

  vec_t vecs [7];
  vec_t b2b  [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v, input bit predriven,
                         input bit chain, input logic [17:0] ndata, input logic [2:0] nsel);
    int          d;
    int          dc;
    int          edges;
    int          match;
    logic        prev_sclk;
    logic [17:0] bits;
    d = v.dut; dc = -1; edges = 0; match = 0; bits = '0;
    if (!predriven) begin
      @(negedge clk);
      tx_data_r[d]  = v.data;
      tx_sel_r[d]   = v.sel;
      tx_valid_r[d] = 1'b1;
    end
    chk({tag, ".ready"}, 32'(ready_w[d]), 1);
    prev_sclk = sclk_w[d];
    @(posedge clk);
    for (int c = 1; c <= v.exp_done + 16 && dc < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        tx_valid_r[d] = 1'b0;
        tx_data_r[d]  = ~v.data;
        tx_sel_r[d]   = v.sel ^ 3'd1;
        chk({tag, ".busy1"}, 32'(busy_w[d]), 1);
        chk({tag, ".mosi1"}, 32'(mosi_w[d]), 32'(v.exp_mosi1));
      end
      if (sclk_w[d] != prev_sclk) edges++;
      if (!prev_sclk && sclk_w[d]) bits = {bits[16:0], mosi_w[d]};
      prev_sclk = sclk_w[d];
      if (done_w[d]) begin
        dc = c;
        chk({tag, ".csn_done"}, 32'(cs_n_w[d]), 32'hF);
        chk({tag, ".mosi_done"}, 32'(mosi_w[d]), 0);
        chk({tag, ".sclk_idle"}, 32'(sclk_w[d]), 32'(cpol_w[d]));
        chk({tag, ".busy_done"}, 32'(busy_w[d]), 0);
`ifdef SPI_MASTER_RX_EN
        chk({tag, ".rx_valid"}, 32'(rxv_w[d]), 1);
        chk({tag, ".rx_data"}, 32'(rx_w[d]), 32'(v.exp_rx));
`endif
        if (chain) begin
          tx_data_r[d]  = ndata;
          tx_sel_r[d]   = nsel;
          tx_valid_r[d] = 1'b1;
        end
      end else if (cs_n_w[d] == v.exp_csn) begin
        match++;
      end
    end
    chk({tag, ".done_cycle"}, 32'(dc), 32'(v.exp_done));
    chk({tag, ".edges"}, 32'(edges), 32'(v.exp_edges));
    chk({tag, ".mosi_bits"}, 32'(bits), 32'(v.exp_bits));
    chk({tag, ".cs_cycles"}, 32'(match), 32'(v.exp_low));
    if (!chain && dc > 0) begin
      @(negedge clk);
      chk({tag, ".done_width"}, 32'(done_w[d]), 0);
    end
    $display("xfer %s dut=%0d data=0x%0h sel=%0d done@%0d edges=%0d bits=0x%0h",
             tag, d, v.data, v.sel, dc, edges, bits);
  endtask

  initial begin
    int dcount;
    vecs[0] = '{0, 18'h000A5, 3'd0, 4'b1110, 18'h000A5, 72, 73, 16, 18'h000A5, 1'b1};
    vecs[1] = '{0, 18'h0003C, 3'd1, 4'b1101, 18'h0003C, 72, 73, 16, 18'h0003C, 1'b0};
    vecs[2] = '{0, 18'h00001, 3'd3, 4'b0111, 18'h00001, 72, 73, 16, 18'h00001, 1'b0};
    vecs[3] = '{1, 18'h000A5, 3'd0, 4'b1110, 18'h000A5, 72, 73, 16, 18'h000A5, 1'b0};
    vecs[4] = '{1, 18'h00081, 3'd2, 4'b1011, 18'h00081, 72, 73, 16, 18'h00081, 1'b0};
    vecs[5] = '{1, 18'h0005A, 3'd3, 4'b1111, 18'h0005A, 72, 73, 16, 18'h0005A, 1'b0};
    vecs[6] = '{2, 18'h2AAAA, 3'd0, 4'b1110, 18'h2AAAA, 1216, 1217, 36, 18'h15555, 1'b1};
    b2b[0]  = '{0, 18'h00096, 3'd2, 4'b1011, 18'h00096, 72, 73, 16, 18'h00096, 1'b1};
    b2b[1]  = '{0, 18'h00069, 3'd3, 4'b0111, 18'h00069, 72, 73, 16, 18'h00069, 1'b0};

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_valid_r[i] = 1'b0;
      tx_data_r[i]  = '0;
      tx_sel_r[i]   = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset%0d.csn", i), 32'(cs_n_w[i]), 32'hF);
      chk($sformatf("reset%0d.sclk", i), 32'(sclk_w[i]), 32'(cpol_w[i]));
      chk($sformatf("reset%0d.mosi", i), 32'(mosi_w[i]), 0);
      chk($sformatf("reset%0d.busy", i), 32'(busy_w[i]), 0);
      chk($sformatf("reset%0d.done", i), 32'(done_w[i]), 0);
      chk($sformatf("reset%0d.ready", i), 32'(ready_w[i]), 0);
`ifdef SPI_MASTER_RX_EN
      chk($sformatf("reset%0d.rx_data", i), 32'(rx_w[i]), 0);
      chk($sformatf("reset%0d.rx_valid", i), 32'(rxv_w[i]), 0);
`endif
    end
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      run_vec($sformatf("v%0d", i), vecs[i], 1'b0, 1'b0, '0, '0);

    // Back-to-back: second command is offered in the done cycle of the first.
    run_vec("b2b0", b2b[0], 1'b0, 1'b1, b2b[1].data, b2b[1].sel);
    run_vec("b2b1", b2b[1], 1'b1, 1'b0, '0, '0);

    // Reset in the middle of a transfer, with a command offered during reset.
    @(negedge clk);
    tx_data_r[0] = 18'h000FF; tx_sel_r[0] = 3'd1; tx_valid_r[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid_r[0] = 1'b0;
    chk("rst.busy_before", 32'(busy_w[0]), 1);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst.csn", 32'(cs_n_w[0]), 32'hF);
    chk("rst.sclk", 32'(sclk_w[0]), 0);
    chk("rst.mosi", 32'(mosi_w[0]), 0);
    chk("rst.busy", 32'(busy_w[0]), 0);
    chk("rst.done", 32'(done_w[0]), 0);
    chk("rst.ready", 32'(ready_w[0]), 0);
    tx_valid_r[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tx_valid_r[0] = 1'b0;
    @(negedge clk);
    chk("rst.no_accept", 32'(busy_w[0]), 0);
    dcount = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done_w[0]) dcount++;
`ifdef SPI_MASTER_RX_EN
      if (rxv_w[0]) dcount++;
`endif
    end
    chk("rst.no_done", 32'(dcount), 0);
    $display("xfer rst sequence: aborted transfer, %0d stray done/rx_valid pulses", dcount);
    run_vec("after_rst", vecs[0], 1'b0, 1'b0, '0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/spi_master_param.md
# spi_master_param

Parametrised SPI master supporting all four SPI modes, configurable word width, configurable SCLK divider, multiple one-hot chip selects and a valid/ready command handshake. Sits between on-board control logic and one or more external SPI peripherals (DAC, display and sensor links). Optional full-duplex MISO capture can be compiled in.

## Interface
Parameters:
- DATA_W, 18: bits per transfer, MSB first; legal range 1..32.
- CLK_DIV, 32: clk cycles per SCLK half-period; legal range 2..256.
- CPOL, 0: SCLK idle level.
- CPHA, 0: 0 = sample on the leading edge, 1 = sample on the trailing edge.
- NUM_CS, 1: number of chip-select lines; legal range 1..8.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk, in, 1: system clock.
  - rst, in, 1: synchronous active-high reset.
- Command handshake:
  - tx_valid, in, 1: command valid.
  - tx_ready, out, 1: block accepts a command.
  - tx_data, in, DATA_W: word to shift out.
  - cs_sel, in, CS_W = max(1, $clog2(NUM_CS)): target chip select, sampled at accept.
- SPI pins:
  - sclk, out, 1: SPI clock, registered.
  - mosi, out, 1: serial data out, registered.
  - miso, in, 1: serial data in. Present only with the RX feature.
  - cs_n, out, NUM_CS: active-low chip selects, registered.
- Status:
  - busy, out, 1: high whenever state ≠ IDLE.
  - done, out, 1: one-cycle pulse at transfer end.
- RX outputs (RX feature only):
  - rx_data, out, DATA_W: captured word.
  - rx_valid, out, 1: one-cycle pulse, coincides with done.

## Operation
- States: IDLE → SETUP → SHIFT → HOLD → IDLE.
- Accept:
  - tx_ready = (state == IDLE) && !rst.
  - A command is accepted on a clk edge where tx_valid && tx_ready. At that edge, tx_data, cs_sel and the mode are latched.
- SETUP:
  - Lasts CLK_DIV cycles.
  - cs_n[cs_sel] = 0; all other cs_n bits stay 1.
  - sclk = CPOL.
  - If CPHA = 0, mosi = tx_data[DATA_W-1] from SETUP entry.
- SHIFT:
  - 2·DATA_W half-periods h = 0..2·DATA_W-1, each CLK_DIV cycles long.
  - sclk = CPOL ^ (h even). The leading edge is at the start of each even h; the trailing edge is at the start of each odd h.
  - CPHA = 0: mosi advances to the next bit at each trailing edge (except the last) and is sampled at leading edges.
  - CPHA = 1: mosi advances at each leading edge (the first bit is driven at h = 0) and is sampled at trailing edges.
- MISO capture: miso is registered on the same clk edge that produces the sample sclk edge. The shift is MSB-first into rx_shift.
- HOLD:
  - Lasts CLK_DIV cycles.
  - sclk = CPOL; cs_n is still asserted; mosi holds its last bit.
- Return to IDLE:
  - All cs_n go to 1; mosi = 0.
  - done = 1 for exactly the first IDLE cycle.
  - rx_data updates and rx_valid pulses in that same cycle.
- cs_sel ≥ NUM_CS: the transfer runs with full timing, no cs_n is asserted, and done still pulses.
- Counters:
  - Divider counter is $clog2(CLK_DIV) bits, cleared at accept. The tick fires at CLK_DIV-1 and the counter wraps to 0.
  - Half-period counter is $clog2(2·DATA_W+1) bits and counts up with no wrap.
- tx_data and cs_sel changes while busy are ignored.

## Timing
- Reset values (held while rst = 1):
  - State = IDLE.
  - sclk = CPOL, mosi = 0, cs_n = all 1s.
  - busy = 0, done = 0, tx_ready = 0.
  - rx_data = 0, rx_valid = 0.
- Accept at edge T0 → SETUP from T0+1. done is high in cycle T0 + 1 + CLK_DIV·(2·DATA_W + 2).
- Back-to-back transfers: tx_ready is high in the done cycle, so the next accept can happen at that edge. cs_n is then high for exactly 1 cycle between words.
- Reset mid-transfer: at the next edge the block returns to IDLE with reset values. No done, no rx_valid.
- rst and tx_valid both high: the command is not accepted.

## Configuration
- SPI_MASTER_RX_EN defined:
  - miso, rx_data and rx_valid ports exist.
  - The capture shift register is built.
- Not defined:
  - Those ports and that logic are absent; the block is transmit-only.
  - All TX timing is identical to the defined case.

## Structure
- Package spi_pkg:
  - spi_state_t enum {IDLE, SETUP, SHIFT, HOLD}.
  - Function cs_width(n) returning max(1, $clog2(n)).
- Sub-module spi_clkgen, parameter CLK_DIV:
  - Inputs clk, rst, clear.
  - Output tick, pulsed on the last cycle of each half-period.

## Test plan
- DATA_W = 8, CLK_DIV = 4, mode 0, cs_sel = 0, tx_data = 0xA5 → mosi at the 8 rising sclk edges is 1,0,1,0,0,1,0,1; cs_n[0] is low for 72 cycles; done at T0+73.
- Same configuration with SPI_MASTER_RX_EN and miso tied to mosi → rx_data = 0xA5 with rx_valid in the done cycle. Repeat with CPOL = 1, CPHA = 1: same data, and sclk idles high.
- NUM_CS = 4, two back-to-back commands to cs_sel = 2 and cs_sel = 3 → only cs_n[2] goes low, then only cs_n[3]. Exactly 1 cycle of all-high cs_n between them. Two done pulses.
- rst asserted at cycle T0+20 of a transfer → next cycle: cs_n = all 1s, sclk = CPOL, mosi = 0, busy = 0, no done. A new command afterwards completes normally.
- NUM_CS = 2, cs_sel = 3 → cs_n stays 2'b11 throughout; done is still at T0+73.
- DATA_W = 18, CLK_DIV = 32, tx_data = 0x2AAAA → 36 sclk edges; done at T0 + 1 + 32·38 = T0+1217.
